// File: rtl/dispensador_billetes_if.sv
// Bill dispenser bus: ATM controller request side plus mechanism handshake.
// INVENTARIO_EN adds the stock-load and out-of-stock signals.
interface dispensador_billetes_if;
  logic        ENTREGAR_DINERO;
  logic [31:0] MONTO;
  logic        BILLETE_ACK;
  logic        BILLETE_STB;
  logic [2:0]  DENOMINACION;
  logic        OCUPADO;
  logic        ENTREGA_COMPLETA;
  logic        MONTO_INVALIDO;
  logic [8:0]  BILLETES_ENTREGADOS;
`ifdef INVENTARIO_EN
  logic        CARGA_STB;
  logic [2:0]  CARGA_DENOM;
  logic [7:0]  CARGA_CANT;
  logic        SIN_BILLETES;

  modport master (
    output ENTREGAR_DINERO, MONTO, BILLETE_ACK,
    output CARGA_STB, CARGA_DENOM, CARGA_CANT,
    input  BILLETE_STB, DENOMINACION, OCUPADO,
    input  ENTREGA_COMPLETA, MONTO_INVALIDO,
    input  BILLETES_ENTREGADOS, SIN_BILLETES
  );

  modport slave (
    input  ENTREGAR_DINERO, MONTO, BILLETE_ACK,
    input  CARGA_STB, CARGA_DENOM, CARGA_CANT,
    output BILLETE_STB, DENOMINACION, OCUPADO,
    output ENTREGA_COMPLETA, MONTO_INVALIDO,
    output BILLETES_ENTREGADOS, SIN_BILLETES
  );
`else
  modport master (
    output ENTREGAR_DINERO, MONTO, BILLETE_ACK,
    input  BILLETE_STB, DENOMINACION, OCUPADO,
    input  ENTREGA_COMPLETA, MONTO_INVALIDO,
    input  BILLETES_ENTREGADOS
  );

  modport slave (
    input  ENTREGAR_DINERO, MONTO, BILLETE_ACK,
    output BILLETE_STB, DENOMINACION, OCUPADO,
    output ENTREGA_COMPLETA, MONTO_INVALIDO,
    output BILLETES_ENTREGADOS
  );
`endif
endinterface

// File: rtl/dispensador_billetes.sv
// Greedy ATM bill dispenser: validate, plan on shadow copies, then hand out bills.
// Optional macro INVENTARIO_EN enables per-denomination stock counters.
module dispensador_billetes (
  input logic CLK,
  input logic RESET,
  dispensador_billetes_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CHECK, PLAN, SELECT, DISPENSE, DONE, FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] sh_q, sh_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  denom_q, denom_d;
  logic [4:0]  disp_plan, disp_sel;
  logic [3:0]  pick;

`ifdef INVENTARIO_EN
  logic [4:0][7:0] inv_q, inv_d;
  logic [4:0][7:0] sh_inv_q, sh_inv_d;
  logic            sin_q, sin_d;
`endif

  function automatic logic [31:0] valor(input logic [2:0] c);
    logic [31:0] v;
    case (c)
      3'd0:    v = 32'd20000;
      3'd1:    v = 32'd10000;
      3'd2:    v = 32'd5000;
      3'd3:    v = 32'd2000;
      3'd4:    v = 32'd1000;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // {found, code}: walks small to large so the largest fit wins
  function automatic logic [3:0] elegir(
    input logic [31:0] r,
    input logic [4:0]  disp
  );
    logic [3:0] res;
    res = '0;
    for (int i = 4; i >= 0; i--) begin
      if (disp[i] && valor(3'(i)) <= r) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

`ifdef INVENTARIO_EN
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      disp_plan[i] = sh_inv_q[i] != 8'd0;
      disp_sel[i]  = inv_q[i] != 8'd0;
    end
  end
`else
  assign disp_plan = 5'b11111;
  assign disp_sel  = 5'b11111;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    denom_d = denom_q;
    pick    = '0;
`ifdef INVENTARIO_EN
    inv_d    = inv_q;
    sh_inv_d = sh_inv_q;
    sin_d    = sin_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ENTREGAR_DINERO) begin
          rem_d   = bus.MONTO;
          cnt_d   = '0;
          state_d = CHECK;
`ifdef INVENTARIO_EN
          sin_d   = 1'b0;
`endif
        end
`ifdef INVENTARIO_EN
        if (bus.CARGA_STB && bus.CARGA_DENOM < 3'd5)
          inv_d[bus.CARGA_DENOM] = bus.CARGA_CANT;
`endif
      end
      CHECK: begin
        if (rem_q == 32'd0 || rem_q > 32'd400000 ||
            (rem_q % 32'd1000) != 32'd0) begin
          state_d = FAIL;
        end else begin
          sh_d    = rem_q;
          state_d = PLAN;
`ifdef INVENTARIO_EN
          sh_inv_d = inv_q;
`endif
        end
      end
      PLAN: begin
        if (sh_q == 32'd0) begin
          state_d = SELECT;
        end else begin
          pick = elegir(sh_q, disp_plan);
          if (!pick[3]) begin
            state_d = FAIL;
`ifdef INVENTARIO_EN
            sin_d   = 1'b1;
`endif
          end else begin
            sh_d = sh_q - valor(pick[2:0]);
`ifdef INVENTARIO_EN
            sh_inv_d[pick[2:0]] = sh_inv_q[pick[2:0]] - 8'd1;
`endif
          end
        end
      end
      SELECT: begin
        pick    = elegir(rem_q, disp_sel);
        denom_d = pick[2:0];
        state_d = DISPENSE;
      end
      DISPENSE: begin
        if (bus.BILLETE_ACK) begin
          rem_d   = rem_q - valor(denom_q);
          cnt_d   = cnt_q + 9'd1;
          state_d = (rem_d == 32'd0) ? DONE : SELECT;
`ifdef INVENTARIO_EN
          inv_d[denom_q] = inv_q[denom_q] - 8'd1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      denom_q <= '0;
`ifdef INVENTARIO_EN
      inv_q    <= '0;
      sh_inv_q <= '0;
      sin_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      denom_q <= denom_d;
`ifdef INVENTARIO_EN
      inv_q    <= inv_d;
      sh_inv_q <= sh_inv_d;
      sin_q    <= sin_d;
`endif
    end
  end

  assign bus.BILLETE_STB         = state_q == DISPENSE;
  assign bus.DENOMINACION        = denom_q;
  assign bus.OCUPADO             = state_q != IDLE;
  assign bus.ENTREGA_COMPLETA    = state_q == DONE;
  assign bus.MONTO_INVALIDO      = state_q == FAIL;
  assign bus.BILLETES_ENTREGADOS = cnt_q;
`ifdef INVENTARIO_EN
  assign bus.SIN_BILLETES        = (state_q == FAIL) && sin_q;
`endif

endmodule

// File: tb/tb_dispensador_billetes.sv
// Scoreboard bench for dispensador_billetes: stimulus pushes expected events,
// a negedge monitor pops and compares bills, completions and rejections.
module tb_dispensador_billetes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispensador_billetes_if bus();

  dispensador_billetes dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  localparam int K_BILL = 0;
  localparam int K_DONE = 1;
  localparam int K_INV  = 2;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int req_cyc = 0;
  int first_stb = 0;
  int stb_len = 0;
  int bills_seen = 0;
  int ack_delay = 1;
  int ack_cnt = 0;
  logic       stb_prev = 1'b0;
  logic [2:0] den_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop(input int kind, input int act, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected event value %0d, queue empty", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == act) passed++;
      else $display("FAIL %s: got kind %0d val %0d expected kind %0d val %0d",
                    nm, kind, act, e.kind, e.val);
    end
  endtask

  // mechanism model: ACK after ack_delay cycles of STB
  always @(posedge clk) begin
    #1;
    if (bus.BILLETE_STB) begin
      ack_cnt++;
      bus.BILLETE_ACK = (ack_cnt == ack_delay);
    end else begin
      ack_cnt = 0;
      bus.BILLETE_ACK = 1'b0;
    end
  end

  always @(negedge clk) begin
    int sin;
    sin = 0;
`ifdef INVENTARIO_EN
    sin = int'(bus.SIN_BILLETES);
`endif
    if (bus.BILLETE_STB) begin
      if (!stb_prev) begin
        if (first_stb == 0) first_stb = cyc;
        stb_len = 1;
      end else begin
        stb_len++;
        chk("den_stable", bus.DENOMINACION, den_prev);
      end
      if (bus.BILLETE_ACK) begin
        pop(K_BILL, bus.DENOMINACION, "bill");
        bills_seen++;
      end
    end
    if (bus.ENTREGA_COMPLETA) pop(K_DONE, bus.BILLETES_ENTREGADOS, "done");
    if (bus.MONTO_INVALIDO) pop(K_INV, sin, "invalid");
    stb_prev = bus.BILLETE_STB;
    den_prev = bus.DENOMINACION;
  end

  task automatic request(input int m);
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b1;
    bus.MONTO = 32'(m);
    first_stb = 0;
    @(posedge clk);
    #1;
    req_cyc = cyc;
    bus.ENTREGAR_DINERO = 1'b0;
    bus.MONTO = 32'd7000;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.OCUPADO && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(bus.OCUPADO), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_stb"}, int'(bus.BILLETE_STB), 0);
    chk({tag, "_den"}, int'(bus.DENOMINACION), 0);
    chk({tag, "_ocupado"}, int'(bus.OCUPADO), 0);
    chk({tag, "_completa"}, int'(bus.ENTREGA_COMPLETA), 0);
    chk({tag, "_invalido"}, int'(bus.MONTO_INVALIDO), 0);
    chk({tag, "_count"}, int'(bus.BILLETES_ENTREGADOS), 0);
  endtask

`ifdef INVENTARIO_EN
  task automatic carga(input int d, input int c);
    @(negedge clk);
    bus.CARGA_STB = 1'b1;
    bus.CARGA_DENOM = 3'(d);
    bus.CARGA_CANT = 8'(c);
    @(posedge clk);
    #1;
    bus.CARGA_STB = 1'b0;
  endtask
`endif

  initial begin
    int bad[3];
    int n;
    int b0;
    bad = '{1500, 0, 410000};
    bus.ENTREGAR_DINERO = 1'b0;
    bus.MONTO = '0;
    bus.BILLETE_ACK = 1'b0;
`ifdef INVENTARIO_EN
    bus.CARGA_STB = 1'b0;
    bus.CARGA_DENOM = '0;
    bus.CARGA_CANT = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

`ifndef INVENTARIO_EN
    // 50000 -> 20000,20000,10000, first STB at 3+3 cycles
    ack_delay = 1;
    push(K_BILL, 0); push(K_BILL, 0); push(K_BILL, 1); push(K_DONE, 3);
    request(50000);
    wait_idle();
    chk("latency_50000", first_stb - req_cyc, 6);
    chk("count_hold", int'(bus.BILLETES_ENTREGADOS), 3);

    foreach (bad[i]) begin
      push(K_INV, 0);
      request(bad[i]);
      n = 0;
      while (bus.OCUPADO && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("invalid_busy_cycles", n, 3);
    end

    // 38000 -> one of each; a second request mid-sequence is ignored
    push(K_BILL, 0); push(K_BILL, 1); push(K_BILL, 2);
    push(K_BILL, 3); push(K_BILL, 4); push(K_DONE, 5);
    request(38000);
    repeat (4) @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b1;
    bus.MONTO = 32'd1000;
    @(negedge clk);
    bus.ENTREGAR_DINERO = 1'b0;
    wait_idle();

    // slow mechanism: STB held 6 cycles
    ack_delay = 6;
    push(K_BILL, 0); push(K_DONE, 1);
    request(20000);
    wait_idle();
    chk("stb_len_slow_ack", stb_len, 6);

    // reset while the second bill of 50000 is presented
    ack_delay = 4;
    push(K_BILL, 0);
    b0 = bills_seen;
    request(50000);
    n = 0;
    while (!(bills_seen > b0 && bus.BILLETE_STB && !bus.BILLETE_ACK) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_second_bill", int'(bus.BILLETE_STB), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero("midreset");
    chk("queue_after_reset", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 1;
    push(K_BILL, 4); push(K_DONE, 1);
    request(1000);
    wait_idle();
`else
    ack_delay = 1;
    carga(0, 1); carga(1, 0); carga(2, 10); carga(3, 0); carga(4, 0);
    push(K_BILL, 0);
    for (int i = 0; i < 6; i++) push(K_BILL, 2);
    push(K_DONE, 7);
    request(50000);
    wait_idle();
    // 5000 stock must now be 4
    for (int i = 0; i < 4; i++) push(K_BILL, 2);
    push(K_DONE, 4);
    request(20000);
    wait_idle();
    push(K_INV, 1);
    request(5000);
    wait_idle();

    carga(0, 1); carga(1, 0); carga(2, 0); carga(3, 0); carga(4, 0);
    push(K_INV, 1);
    request(30000);
    wait_idle();
    // 20000 stock untouched by the failed plan
    push(K_BILL, 0); push(K_DONE, 1);
    request(20000);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
